// File: rtl/pkt_read_ctrl_pkg.sv
// Shared types and constants for the packet read controller.
// Optional feature macro: PKT_WATCHDOG_EN (packet-length watchdog).
package pkt_read_ctrl_pkg;

   // Flit-type field width and one-hot codes. Any non-header, non-tail code
   // (BODY or an invalid pattern) is handled as plain data or as an orphan.
   localparam int FT_W_C = 3;
   localparam logic [FT_W_C-1:0] FT_HEADER = 3'b001;
   localparam logic [FT_W_C-1:0] FT_TAIL   = 3'b100;

   // Per-channel controller state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } ch_state_e;

endpackage

// File: rtl/pkt_read_ctrl_if.sv
// Bundle of per-channel FIFO-head, allocator and downstream signals.
// master: the read controller. slave: the FIFO/allocator environment.
interface pkt_read_ctrl_if #(
   parameter int NUM_CH = 5,
   parameter int FT_W   = 3
);
   logic [NUM_CH-1:0]      empty;
   logic [NUM_CH*FT_W-1:0] flit_type;
   logic [NUM_CH-1:0]      grant;
   logic [NUM_CH-1:0]      out_ready;
   logic [NUM_CH-1:0]      rd_en;
   logic [NUM_CH-1:0]      req;
   logic [NUM_CH-1:0]      pkt_active;
   logic [NUM_CH-1:0]      pkt_len_err;

   modport master (
      input  empty, flit_type, grant, out_ready,
      output rd_en, req, pkt_active, pkt_len_err
   );

   modport slave (
      output empty, flit_type, grant, out_ready,
      input  rd_en, req, pkt_active, pkt_len_err
   );
endinterface

// File: rtl/pkt_read_ctrl_ch.sv
// One channel of the packet read controller: IDLE -> REQ -> XFER -> IDLE,
// with a saturating flit counter and, when PKT_WATCHDOG_EN is defined,
// a sticky packet-length watchdog.
module pkt_read_ch
   import pkt_read_ctrl_pkg::*;
#(
   parameter int FT_W        = FT_W_C,
   parameter int CNT_W       = 4,
   parameter int MAX_PKT_LEN = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            empty_i,
   input  logic [FT_W-1:0] flit_type_i,
   input  logic            grant_i,
   input  logic            out_ready_i,
   output logic            rd_en_o,
   output logic            req_o,
   output logic            pkt_active_o,
   output logic            pkt_len_err_o
);

   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   // The watchdog limit has to fit in the counter or it could never fire.
   if (MAX_PKT_LEN < 2 || MAX_PKT_LEN > 2**CNT_W - 1) begin : g_bad_len
      $error("pkt_read_ch: MAX_PKT_LEN out of range for CNT_W");
   end

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             is_hdr, is_tail, pop;

   assign is_hdr  = (flit_type_i == FT_HEADER);
   assign is_tail = (flit_type_i == FT_TAIL);

   // State register: FSM state, flit counter and sticky error flag
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: header detect, grant capture, drain until tail (or watchdog)
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: if (!empty_i && is_hdr) state_d = ST_REQ;
         ST_REQ:  if (grant_i) state_d = ST_XFER;
         ST_XFER: begin
            if (pop) begin
               if (is_tail) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
`ifdef PKT_WATCHDOG_EN
                  // The pop that reaches the limit without being a tail ends the packet.
                  if (cnt_d == CNT_W'(MAX_PKT_LEN)) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode: pop orphans in IDLE, request in REQ, drain in XFER
   always_comb begin
      pop          = 1'b0;
      req_o        = 1'b0;
      pkt_active_o = 1'b0;
      unique case (state_q)
         ST_IDLE: pop = !empty_i && !is_hdr;
         ST_REQ:  req_o = 1'b1;
         ST_XFER: begin
            pkt_active_o = 1'b1;
            pop          = !empty_i && out_ready_i;
         end
         default: ;
      endcase
   end

   // The orphan-discard pop depends only on FIFO inputs in IDLE, so it is
   // masked while reset is held to keep rd_en quiet until release.
   assign rd_en_o       = pop && rst;
   assign pkt_len_err_o = err_q;

endmodule

// File: rtl/pkt_read_ctrl.sv
// Packet-aware read controller for all router input FIFOs.
// One independent pkt_read_ch per channel; PKT_WATCHDOG_EN enables the
// packet-length watchdog (pkt_len_err stays 0 when undefined).
module pkt_read_ctrl
   import pkt_read_ctrl_pkg::*;
#(
   parameter int NUM_CH      = 5,
   parameter int FT_W        = FT_W_C,
   parameter int CNT_W       = 4,
   parameter int MAX_PKT_LEN = 15
) (
   input  logic             clk,
   input  logic             rst,
   pkt_read_ctrl_if.master  bus
);

   logic [NUM_CH-1:0] rd_en, req, pkt_active, pkt_len_err;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pkt_read_ch #(
         .FT_W        (FT_W),
         .CNT_W       (CNT_W),
         .MAX_PKT_LEN (MAX_PKT_LEN)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .empty_i       (bus.empty[i]),
         .flit_type_i   (bus.flit_type[i*FT_W +: FT_W]),
         .grant_i       (bus.grant[i]),
         .out_ready_i   (bus.out_ready[i]),
         .rd_en_o       (rd_en[i]),
         .req_o         (req[i]),
         .pkt_active_o  (pkt_active[i]),
         .pkt_len_err_o (pkt_len_err[i])
      );
   end

   assign bus.rd_en       = rd_en;
   assign bus.req         = req;
   assign bus.pkt_active  = pkt_active;
   assign bus.pkt_len_err = pkt_len_err;

endmodule

// File: tb/tb_pkt_read_ctrl.sv
// Directed bench for pkt_read_ctrl. A tiny FIFO model per channel supplies
// empty/flit_type and pops on rd_en; expected vectors are hand-derived.
module tb_pkt_read_ctrl;

   localparam int NUM_CH = 5;
   localparam int FT_W   = 3;
   localparam int DEPTH  = 32;
   localparam logic [2:0] H = 3'b001;
   localparam logic [2:0] B = 3'b010;
   localparam logic [2:0] T = 3'b100;

`ifdef PKT_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   pkt_read_ctrl_if #(.NUM_CH(NUM_CH), .FT_W(FT_W)) bus ();

   pkt_read_ctrl #(
      .NUM_CH      (NUM_CH),
      .FT_W        (FT_W),
      .CNT_W       (4),
      .MAX_PKT_LEN (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [2:0]        fmem [NUM_CH][DEPTH];
   int                rp [NUM_CH];
   int                wp [NUM_CH];
   int                n_chk = 0;
   int                n_err = 0;
   logic [NUM_CH-1:0] pop_s;

   task automatic refresh();
      for (int i = 0; i < NUM_CH; i++) begin
         bus.empty[i] = (rp[i] == wp[i]);
         bus.flit_type[i*FT_W +: FT_W] = (rp[i] == wp[i]) ? 3'b000 : fmem[i][rp[i] % DEPTH];
      end
   endtask

   task automatic push(input int ch, input logic [2:0] ft);
      fmem[ch][wp[ch] % DEPTH] = ft;
      wp[ch]++;
   endtask

   task automatic flush_all();
      for (int i = 0; i < NUM_CH; i++) rp[i] = wp[i];
   endtask

   // Sample rd_en at the negedge, then pop the model FIFOs just after the edge.
   task automatic advance();
      pop_s = bus.rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++)
         if (pop_s[i] && rp[i] != wp[i]) rp[i]++;
      refresh();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [4:0] rd, input logic [4:0] rq,
                          input logic [4:0] ac, input logic [4:0] er);
      chk({tag, ".rd_en"},       32'(bus.rd_en),       32'(rd));
      chk({tag, ".req"},         32'(bus.req),         32'(rq));
      chk({tag, ".pkt_active"},  32'(bus.pkt_active),  32'(ac));
      chk({tag, ".pkt_len_err"}, 32'(bus.pkt_len_err), 32'(er));
   endtask

   // One directed cycle: drive grant/out_ready, check at the negedge, advance.
   task automatic cyc(input string tag, input logic [4:0] g, input logic [4:0] ordy,
                      input logic [4:0] rd, input logic [4:0] rq,
                      input logic [4:0] ac, input logic [4:0] er);
      bus.grant     = g;
      bus.out_ready = ordy;
      @(negedge clk);
      chk_all(tag, rd, rq, ac, er);
      advance();
   endtask

   initial begin
      logic [4:0] ac3, er3;
      for (int i = 0; i < NUM_CH; i++) begin
         rp[i] = 0;
         wp[i] = 0;
      end
      bus.grant     = '0;
      bus.out_ready = '0;
      refresh();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all("reset", 5'b0, 5'b0, 5'b0, 5'b0);
      advance();
      rst = 1'b1;

      // 1: ch0 H,B,T; grant in cycle 2 -> req@1, rd_en@3..5, idle@6
      push(0, H); push(0, B); push(0, T); refresh();
      cyc("t1c0", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t1c1", 5'b00000, 5'h1F, 5'b00000, 5'b00001, 5'b00000, 5'b0);
      cyc("t1c2", 5'b00001, 5'h1F, 5'b00000, 5'b00001, 5'b00000, 5'b0);
      cyc("t1c3", 5'b00000, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t1c4", 5'b00000, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t1c5", 5'b00000, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t1c6", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);

      // 2: ch1 H,B,B,B,T with out_ready[1] low for 3 cycles mid-body
      push(1, H); push(1, B); push(1, B); push(1, B); push(1, T); refresh();
      cyc("t2c0",  5'b00000, 5'h1F,     5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t2c1",  5'b00000, 5'h1F,     5'b00000, 5'b00010, 5'b00000, 5'b0);
      cyc("t2c2",  5'b00010, 5'h1F,     5'b00000, 5'b00010, 5'b00000, 5'b0);
      cyc("t2c3",  5'b00000, 5'h1F,     5'b00010, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c4",  5'b00000, 5'h1F,     5'b00010, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c5",  5'b00000, 5'b11101, 5'b00000, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c6",  5'b00000, 5'b11101, 5'b00000, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c7",  5'b00000, 5'b11101, 5'b00000, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c8",  5'b00000, 5'h1F,     5'b00010, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c9",  5'b00000, 5'h1F,     5'b00010, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c10", 5'b00000, 5'h1F,     5'b00010, 5'b00000, 5'b00010, 5'b0);
      cyc("t2c11", 5'b00000, 5'h1F,     5'b00000, 5'b00000, 5'b00000, 5'b0);

      // 3: ch2 orphan BODY in IDLE -> one-cycle discard, no request
      push(2, B); refresh();
      cyc("t3c0", 5'b00000, 5'h1F, 5'b00100, 5'b00000, 5'b00000, 5'b0);
      cyc("t3c1", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);

      // 4: all channels H,T together, grants staggered one per cycle
      for (int i = 0; i < NUM_CH; i++) begin
         push(i, H); push(i, T);
      end
      refresh();
      cyc("t4c0", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t4c1", 5'b00000, 5'h1F, 5'b00000, 5'b11111, 5'b00000, 5'b0);
      cyc("t4c2", 5'b00001, 5'h1F, 5'b00000, 5'b11111, 5'b00000, 5'b0);
      cyc("t4c3", 5'b00010, 5'h1F, 5'b00001, 5'b11110, 5'b00001, 5'b0);
      cyc("t4c4", 5'b00100, 5'h1F, 5'b00011, 5'b11100, 5'b00011, 5'b0);
      cyc("t4c5", 5'b01000, 5'h1F, 5'b00110, 5'b11000, 5'b00110, 5'b0);
      cyc("t4c6", 5'b10000, 5'h1F, 5'b01100, 5'b10000, 5'b01100, 5'b0);
      cyc("t4c7", 5'b00000, 5'h1F, 5'b11000, 5'b00000, 5'b11000, 5'b0);
      cyc("t4c8", 5'b00000, 5'h1F, 5'b10000, 5'b00000, 5'b10000, 5'b0);
      cyc("t4c9", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);

      // 7: back-to-back packets on ch0 with grant held (ignored in IDLE/XFER),
      //    invalid one-hot codes on ch2 discarded as orphans
      push(0, H); push(0, T); push(0, H); push(0, T);
      push(2, 3'b011); push(2, 3'b000); refresh();
      cyc("t7c0", 5'b00001, 5'h1F, 5'b00100, 5'b00000, 5'b00000, 5'b0);
      cyc("t7c1", 5'b00001, 5'h1F, 5'b00100, 5'b00001, 5'b00000, 5'b0);
      cyc("t7c2", 5'b00001, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t7c3", 5'b00001, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t7c4", 5'b00001, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t7c5", 5'b00001, 5'h1F, 5'b00000, 5'b00001, 5'b00000, 5'b0);
      cyc("t7c6", 5'b00001, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t7c7", 5'b00001, 5'h1F, 5'b00001, 5'b00000, 5'b00001, 5'b0);
      cyc("t7c8", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);

      // 5: ch3 header + 20 bodies, no tail. With the watchdog the 15th pop
      //    aborts the packet and the rest drain as orphans; without it the
      //    channel keeps draining and stays in XFER.
      push(3, H);
      for (int i = 0; i < 20; i++) push(3, B);
      refresh();
      cyc("t5c0", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t5c1", 5'b00000, 5'h1F, 5'b00000, 5'b01000, 5'b00000, 5'b0);
      cyc("t5c2", 5'b01000, 5'h1F, 5'b00000, 5'b01000, 5'b00000, 5'b0);
      for (int k = 3; k <= 17; k++)
         cyc($sformatf("t5c%0d", k), 5'b00000, 5'h1F, 5'b01000, 5'b00000, 5'b01000, 5'b0);
      ac3 = WD ? 5'b00000 : 5'b01000;
      er3 = WD ? 5'b01000 : 5'b00000;
      for (int k = 18; k <= 23; k++)
         cyc($sformatf("t5c%0d", k), 5'b00000, 5'h1F, 5'b01000, 5'b00000, ac3, er3);
      cyc("t5c24", 5'b00000, 5'h1F, 5'b00000, 5'b00000, ac3, er3);

      // 6: async reset in the middle of a ch4 transfer
      push(4, H); push(4, B); push(4, B); push(4, B); push(4, T); refresh();
      cyc("t6c0", 5'b00000, 5'h1F, 5'b00000, 5'b00000, ac3, er3);
      cyc("t6c1", 5'b00000, 5'h1F, 5'b00000, 5'b10000, ac3, er3);
      cyc("t6c2", 5'b10000, 5'h1F, 5'b00000, 5'b10000, ac3, er3);
      cyc("t6c3", 5'b00000, 5'h1F, 5'b10000, 5'b00000, ac3 | 5'b10000, er3);
      @(negedge clk);
      chk_all("t6c4", 5'b10000, 5'b00000, ac3 | 5'b10000, er3);
      #2 rst = 1'b0;
      #1 chk_all("t6_rst_async", 5'b0, 5'b0, 5'b0, 5'b0);
      flush_all();
      refresh();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_all("t6_rst_held", 5'b0, 5'b0, 5'b0, 5'b0);
      advance();
      rst = 1'b1;
      cyc("t6_rel0", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);
      cyc("t6_rel1", 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 5'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
